fp_execute_stage5: RTL
======================

# fp_execute_stage5

Final stage of the floating point pipeline. It consumes the registered stage-4 add/multiply intermediates (significand, exponent, sign, normalization shift, product, inf/nan flags) and produces packed per-lane 32-bit results. The work per lane is post-normalization, round-to-nearest-even, exponent overflow/underflow handling, special-value substitution and FTOI completion. It also keeps per-thread sticky exception flags. Its output feeds writeback.

## Interface
Parameters:
- NUM_THREADS, `THREADS_PER_CORE: threads tracked by sticky flags.
- LANES, `VECTOR_LANES: lanes processed in parallel.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- fx4_instruction_valid / fx4_instruction / fx4_mask_value / fx4_thread_idx / fx4_subcycle  in  (types as stage 4)  instruction sideband.
- fx4_result_is_inf, fx4_result_is_nan  in  LANES  special-value flags.
- fx4_add_significand  in  LANES×32; fx4_add_exponent  in  LANES×8; fx4_add_result_sign, fx4_logical_subtract  in  LANES; fx4_norm_shift  in  LANES×6.
- fx4_significand_product  in  LANES×64; fx4_mul_exponent  in  LANES×8; fx4_mul_sign  in  LANES.
- flag_clear_en  in  1; flag_clear_thread  in  thread_idx_t: clear one thread's sticky flags.
- fx5_instruction_valid, fx5_instruction, fx5_mask_value, fx5_thread_idx, fx5_subcycle  out  registered sideband.
- fx5_result  out  LANES×32  packed result.
- fx5_overflow_flags, fx5_inexact_flags  out  NUM_THREADS  sticky per-thread flags.

## Operation
- Path select uses fx4_instruction.alu_op: OP_FTOI, multiply ops, and all other FP ops (the add path).
- Add path:
  - shifted = add_significand << norm_shift. Leading one lands at bit 31.
  - mantissa = shifted[30:8], round bit = shifted[7], sticky = |shifted[6:0].
  - exponent = add_exponent + 1 − norm_shift, computed at 10 bits signed.
- Multiply path:
  - If product[47]: mantissa = product[46:24], round = product[23], sticky = |product[22:0], exponent = mul_exponent + 1.
  - Else: mantissa = product[45:23], round = product[22], sticky = |product[21:0], exponent = mul_exponent.
- Rounding: increment mantissa when round & (sticky | mantissa[0]). A mantissa carry-out increments the exponent and zeroes the mantissa.
- Result packing: {sign, exponent[7:0], mantissa}.
- Boundary conditions, in priority order:
  - nan → 32'h7FFFFFFF.
  - inf → {sign, 8'hFF, 23'h0}.
  - add significand == 0 → +0, or −0 only when !logical_subtract & sign.
  - final exponent ≥ 255 → {sign, 8'hFF, 0}, and overflow is raised.
  - final exponent ≤ 0 → {sign, 31'h0}. This is flush to zero; inexact is raised.
- FTOI: value = add_significand << norm_shift; the result is the two's complement of value when add_result_sign is set. No rounding.
- Sticky flags update only when fx4_instruction_valid, and only from lanes set in fx4_mask_value:
  - overflow_flags[thread] |= any lane overflowed.
  - inexact_flags[thread] |= any lane had round|sticky or flushed.
- flag_clear_en clears the selected thread's flags. A same-cycle set for the same thread wins over the clear.
- Masked-off lanes still compute fx5_result. Writeback ignores them.

## Timing
- Latency: 1 cycle, fully pipelined, one instruction per cycle, no stalls.
- All fx5_* outputs are registered.
- Reset values: fx5_instruction_valid, fx5_instruction, fx5_mask_value, fx5_thread_idx, fx5_subcycle, fx5_result, both flag vectors all 0.
- Reset mid-stream drops the in-flight instruction; the first valid output appears the cycle after the first valid input following deassert.
- Flags are visible on the cycle after the causing instruction, i.e. the same cycle as its fx5_result.

## Configuration
- FP_ROUND_NEAREST_EN defined: round-to-nearest-even as described above.
- FP_ROUND_NEAREST_EN undefined: truncation. The mantissa is never incremented; inexact is still raised on round|sticky.

## Test plan
- Add 1.0+1.0: significand 32'h80000000, norm_shift 0, exponent 127 → fx5_result 32'h40000000, no flags.
- Multiply 1.5×1.5: product 64'h0000_9000_0000_0000, mul_exponent 127 → 32'h40100000.
- Tie rounding: add significand 32'h400000C0, norm_shift 1, exponent 127 → 32'h3F800002 with the macro, 32'h3F800001 without; inexact set for that thread.
- Overflow: significand 32'h80000000, exponent 254, thread 2 → 32'h7F800000, overflow_flags[2]=1. Then flag_clear_en for thread 2 → flag is 0 the next cycle.
- Specials and zero: nan lane → 32'h7FFFFFFF; inf with sign 1 → 32'hFF800000; zero significand with logical_subtract → 32'h00000000. Masked lanes leave the flags unchanged.
- Reset asserted with valid in flight → all outputs 0 the same cycle (asynchronous); back-to-back valid instructions after release → one result per cycle.

Source files
------------

// File: rtl/fp_execute_stage5_if.sv
// Shared types and the stage-4 -> stage-5 -> writeback bundle for the FP execute tail.
// slave modport is the stage-5 view; master is the driver/consumer side (stage 4, writeback, benches).
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 4
`endif

package fp_execute_stage5_pkg;
    typedef enum logic [3:0] {
        OP_FADD = 4'd0,
        OP_FSUB = 4'd1,
        OP_FMUL = 4'd2,
        OP_FTOI = 4'd3,
        OP_ITOF = 4'd4,
        OP_FCMP = 4'd5
    } alu_op_t;

    typedef struct packed {
        logic       has_dest;
        logic [4:0] dest_reg;
        alu_op_t    alu_op;
    } instruction_t;

    typedef logic [3:0] subcycle_t;
endpackage

interface fp_execute_stage5_if #(
    parameter int LANES       = `VECTOR_LANES,
    parameter int NUM_THREADS = `THREADS_PER_CORE
);
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    logic                                 fx4_instruction_valid;
    fp_execute_stage5_pkg::instruction_t  fx4_instruction;
    logic [LANES-1:0]                     fx4_mask_value;
    logic [TW-1:0]                        fx4_thread_idx;
    fp_execute_stage5_pkg::subcycle_t     fx4_subcycle;
    logic [LANES-1:0]                     fx4_result_is_inf;
    logic [LANES-1:0]                     fx4_result_is_nan;
    logic [LANES-1:0][31:0]               fx4_add_significand;
    logic [LANES-1:0][7:0]                fx4_add_exponent;
    logic [LANES-1:0]                     fx4_add_result_sign;
    logic [LANES-1:0]                     fx4_logical_subtract;
    logic [LANES-1:0][5:0]                fx4_norm_shift;
    logic [LANES-1:0][63:0]               fx4_significand_product;
    logic [LANES-1:0][7:0]                fx4_mul_exponent;
    logic [LANES-1:0]                     fx4_mul_sign;
    logic                                 flag_clear_en;
    logic [TW-1:0]                        flag_clear_thread;

    logic                                 fx5_instruction_valid;
    fp_execute_stage5_pkg::instruction_t  fx5_instruction;
    logic [LANES-1:0]                     fx5_mask_value;
    logic [TW-1:0]                        fx5_thread_idx;
    fp_execute_stage5_pkg::subcycle_t     fx5_subcycle;
    logic [LANES-1:0][31:0]               fx5_result;
    logic [NUM_THREADS-1:0]               fx5_overflow_flags;
    logic [NUM_THREADS-1:0]               fx5_inexact_flags;

    modport slave (
        input  fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx, fx4_subcycle,
               fx4_result_is_inf, fx4_result_is_nan, fx4_add_significand, fx4_add_exponent,
               fx4_add_result_sign, fx4_logical_subtract, fx4_norm_shift,
               fx4_significand_product, fx4_mul_exponent, fx4_mul_sign,
               flag_clear_en, flag_clear_thread,
        output fx5_instruction_valid, fx5_instruction, fx5_mask_value, fx5_thread_idx, fx5_subcycle,
               fx5_result, fx5_overflow_flags, fx5_inexact_flags
    );

    modport master (
        output fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx, fx4_subcycle,
               fx4_result_is_inf, fx4_result_is_nan, fx4_add_significand, fx4_add_exponent,
               fx4_add_result_sign, fx4_logical_subtract, fx4_norm_shift,
               fx4_significand_product, fx4_mul_exponent, fx4_mul_sign,
               flag_clear_en, flag_clear_thread,
        input  fx5_instruction_valid, fx5_instruction, fx5_mask_value, fx5_thread_idx, fx5_subcycle,
               fx5_result, fx5_overflow_flags, fx5_inexact_flags
    );
endinterface

// File: rtl/fp_execute_stage5.sv
// FP pipeline final stage: normalize, round (nearest-even under FP_ROUND_NEAREST_EN, else truncate), pack, FTOI, sticky flags.
// Latency 1 cycle, fully pipelined, one instruction per cycle.
// No backpressure: never stalls, every accepted instruction emerges the next cycle.
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 4
`endif

module fp_execute_stage5
    import fp_execute_stage5_pkg::*;
#(
    parameter int NUM_THREADS = `THREADS_PER_CORE,
    parameter int LANES       = `VECTOR_LANES
) (
    input  logic                    clk,
    input  logic                    reset,
    fp_execute_stage5_if.slave      bus
);
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    logic                   is_mul;
    logic                   is_ftoi;
    logic [LANES-1:0][31:0] lane_result;
    logic [LANES-1:0]       lane_ovf;
    logic [LANES-1:0]       lane_inx;
    logic                   any_ovf;
    logic                   any_inx;

    assign is_mul  = (bus.fx4_instruction.alu_op == OP_FMUL);
    assign is_ftoi = (bus.fx4_instruction.alu_op == OP_FTOI);

    always_comb begin : lane_calc
        logic [31:0]       shifted;
        logic [22:0]       mant;
        logic [22:0]       mant_fin;
        logic [23:0]       mant_rnd;
        logic              rnd_bit;
        logic              stk_bit;
        logic              sign;
        logic              round_inc;
        logic signed [9:0] exp_pre;
        logic signed [9:0] exp_fin;
        lane_result = '0;
        lane_ovf    = '0;
        lane_inx    = '0;
        for (int l = 0; l < LANES; l++) begin
            shifted = bus.fx4_add_significand[l] << bus.fx4_norm_shift[l];
            if (is_mul) begin
                sign = bus.fx4_mul_sign[l];
                // Product of two 1.x significands lies in [1,4); bit 47 says which half.
                if (bus.fx4_significand_product[l][47]) begin
                    mant    = bus.fx4_significand_product[l][46:24];
                    rnd_bit = bus.fx4_significand_product[l][23];
                    stk_bit = |bus.fx4_significand_product[l][22:0];
                    exp_pre = $signed({2'b00, bus.fx4_mul_exponent[l]}) + 10'sd1;
                end else begin
                    mant    = bus.fx4_significand_product[l][45:23];
                    rnd_bit = bus.fx4_significand_product[l][22];
                    stk_bit = |bus.fx4_significand_product[l][21:0];
                    exp_pre = $signed({2'b00, bus.fx4_mul_exponent[l]});
                end
            end else begin
                sign    = bus.fx4_add_result_sign[l];
                mant    = shifted[30:8];
                rnd_bit = shifted[7];
                stk_bit = |shifted[6:0];
                exp_pre = $signed({2'b00, bus.fx4_add_exponent[l]}) + 10'sd1
                        - $signed({4'b0000, bus.fx4_norm_shift[l]});
            end
`ifdef FP_ROUND_NEAREST_EN
            round_inc = rnd_bit & (stk_bit | mant[0]);
`else
            round_inc = 1'b0;
`endif
            mant_rnd = {1'b0, mant} + {23'b0, round_inc};
            if (mant_rnd[23]) begin
                exp_fin  = exp_pre + 10'sd1;
                mant_fin = '0;
            end else begin
                exp_fin  = exp_pre;
                mant_fin = mant_rnd[22:0];
            end

            if (is_ftoi) begin
                lane_result[l] = bus.fx4_add_result_sign[l] ? (~shifted + 32'd1) : shifted;
            end else if (bus.fx4_result_is_nan[l]) begin
                lane_result[l] = 32'h7FFF_FFFF;
            end else if (bus.fx4_result_is_inf[l]) begin
                lane_result[l] = {sign, 8'hFF, 23'h0};
            end else if (!is_mul && bus.fx4_add_significand[l] == 32'h0) begin
                // Exact cancellation yields +0; only a same-sign add of zeros keeps -0.
                lane_result[l] = {!bus.fx4_logical_subtract[l] & sign, 31'h0};
            end else if (exp_fin >= 10'sd255) begin
                lane_result[l] = {sign, 8'hFF, 23'h0};
                lane_ovf[l]    = 1'b1;
                lane_inx[l]    = rnd_bit | stk_bit;
            end else if (exp_fin <= 10'sd0) begin
                lane_result[l] = {sign, 31'h0};
                lane_inx[l]    = 1'b1;
            end else begin
                lane_result[l] = {sign, exp_fin[7:0], mant_fin};
                lane_inx[l]    = rnd_bit | stk_bit;
            end
        end
    end

    assign any_ovf = bus.fx4_instruction_valid & |(lane_ovf & bus.fx4_mask_value);
    assign any_inx = bus.fx4_instruction_valid & |(lane_inx & bus.fx4_mask_value);

    logic unused_product_hi;
    always_comb begin
        unused_product_hi = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            unused_product_hi = unused_product_hi | (|bus.fx4_significand_product[l][63:48]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.fx5_instruction_valid <= 1'b0;
            bus.fx5_instruction       <= '0;
            bus.fx5_mask_value        <= '0;
            bus.fx5_thread_idx        <= '0;
            bus.fx5_subcycle          <= '0;
            bus.fx5_result            <= '0;
            bus.fx5_overflow_flags    <= '0;
            bus.fx5_inexact_flags     <= '0;
        end else begin
            bus.fx5_instruction_valid <= bus.fx4_instruction_valid;
            bus.fx5_instruction       <= bus.fx4_instruction;
            bus.fx5_mask_value        <= bus.fx4_mask_value;
            bus.fx5_thread_idx        <= bus.fx4_thread_idx;
            bus.fx5_subcycle          <= bus.fx4_subcycle;
            bus.fx5_result            <= lane_result;
            // Clear is applied first so a same-cycle set on that thread survives.
            for (int t = 0; t < NUM_THREADS; t++) begin
                bus.fx5_overflow_flags[t] <=
                    (bus.fx5_overflow_flags[t] & ~(bus.flag_clear_en && bus.flag_clear_thread == TW'(t)))
                    | (any_ovf && bus.fx4_thread_idx == TW'(t));
                bus.fx5_inexact_flags[t] <=
                    (bus.fx5_inexact_flags[t] & ~(bus.flag_clear_en && bus.flag_clear_thread == TW'(t)))
                    | (any_inx && bus.fx4_thread_idx == TW'(t));
            end
        end
    end
endmodule
